// File: rtl/kpg_pkg.sv
// kpg_pkg: kill/propagate/generate carry encoding shared by the prefix adder.
// Used by kpg_prefix_adder_pipe and kpg_prefix_stage.
package kpg_pkg;

    // Two-bit carry code. The value 01 is never produced.
    typedef enum logic [1:0] {
        KILL = 2'b00,
        PROP = 2'b10,
        GEN  = 2'b11
    } kpg_t;

    // A resolved code (KILL/GEN) wins; a propagating code defers to the code below it.
    function automatic kpg_t kpg_combine(input kpg_t cur, input kpg_t prev);
        return (cur == PROP) ? prev : cur;
    endfunction

    // Classify one bit pair.
    function automatic kpg_t kpg_encode(input logic a_bit, input logic b_bit);
        kpg_t code;
        if (a_bit & b_bit)
            code = GEN;
        else if (~a_bit & ~b_bit)
            code = KILL;
        else
            code = PROP;
        return code;
    endfunction

endpackage

// File: rtl/kpg_prefix_stage.sv
// kpg_prefix_stage: one Kogge-Stone prefix level plus its pipeline register.
// Position i (i >= DIST) merges with position i-DIST; lower positions pass through.
// The code vector holds WIDTH+1 two-bit codes; position 0 is the carry in.
module kpg_prefix_stage
    import kpg_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   adv,
    input  logic                   valid_in,
    input  logic [2*(WIDTH+1)-1:0] code_in,
    input  logic [WIDTH-1:0]       p_in,
    input  logic [TAG_W-1:0]       tag_in,
    output logic                   valid_out,
    output logic [2*(WIDTH+1)-1:0] code_out,
    output logic [WIDTH-1:0]       p_out,
    output logic [TAG_W-1:0]       tag_out
);

    logic [2*(WIDTH+1)-1:0] code_next;

    for (genvar i = 0; i <= WIDTH; i++) begin : g_pos
        if (i >= DIST) begin : g_merge
            assign code_next[2*i +: 2] = kpg_combine(kpg_t'(code_in[2*i +: 2]),
                                                     kpg_t'(code_in[2*(i-DIST) +: 2]));
        end else begin : g_pass
            assign code_next[2*i +: 2] = code_in[2*i +: 2];
        end
    end

    // Level register; the whole pipe freezes together when the output is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            code_out  <= '0;
            p_out     <= '0;
            tag_out   <= '0;
        end else if (adv) begin
            valid_out <= valid_in;
            code_out  <= code_next;
            p_out     <= p_in;
            tag_out   <= tag_in;
        end
    end

endmodule

// File: rtl/kpg_prefix_adder_pipe.sv
// kpg_prefix_adder_pipe: fully pipelined Kogge-Stone adder with valid/ready flow
// control, tag pass-through and signed overflow.
// Optional macro KPG_ADD_SUB_EN adds the 'sub' port (a - b via ~b and carry-in 1).
module kpg_prefix_adder_pipe
    import kpg_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef KPG_ADD_SUB_EN
    input  logic             sub,
`endif
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int LAT    = LEVELS + 1;
    localparam int CW     = 2 * (WIDTH + 1);

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic [CW-1:0]    code_enc;

    logic [CW-1:0]    code_pipe  [0:LEVELS];
    logic [WIDTH-1:0] p_pipe     [0:LEVELS];
    logic [TAG_W-1:0] tag_pipe   [0:LEVELS];
    logic             valid_pipe [0:LEVELS];

    assign adv      = ~(out_valid & ~out_ready);
    assign in_ready = adv;

`ifdef KPG_ADD_SUB_EN
    assign b_eff = sub ? ~b : b;
    assign c0    = sub ? 1'b1 : cin;
`else
    assign b_eff = b;
    assign c0    = cin;
`endif

    // Position 0 carries c0; position i+1 carries the code of bit pair i.
    assign code_enc[1:0] = c0 ? GEN : KILL;
    for (genvar i = 0; i < WIDTH; i++) begin : g_enc
        assign code_enc[2*(i+1) +: 2] = kpg_encode(a[i], b_eff[i]);
    end

    // Stage 0: capture encoded operands; a bubble still loads data but with valid low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_pipe[0] <= 1'b0;
            code_pipe[0]  <= '0;
            p_pipe[0]     <= '0;
            tag_pipe[0]   <= '0;
        end else if (adv) begin
            valid_pipe[0] <= in_valid;
            code_pipe[0]  <= code_enc;
            p_pipe[0]     <= a ^ b_eff;
            tag_pipe[0]   <= in_tag;
        end
    end

    for (genvar k = 1; k <= LEVELS; k++) begin : g_level
        kpg_prefix_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << (k - 1)),
            .TAG_W (TAG_W)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .adv       (adv),
            .valid_in  (valid_pipe[k-1]),
            .code_in   (code_pipe[k-1]),
            .p_in      (p_pipe[k-1]),
            .tag_in    (tag_pipe[k-1]),
            .valid_out (valid_pipe[k]),
            .code_out  (code_pipe[k]),
            .p_out     (p_pipe[k]),
            .tag_out   (tag_pipe[k])
        );
    end

    // Final carries. The prefix tree spans WIDTH positions, so the top position
    // still lacks position 0 when every bit propagates; fold c0 in here.
    logic [WIDTH:0] carry;
    kpg_t           top_code;

    assign top_code = kpg_combine(kpg_t'(code_pipe[LEVELS][2*WIDTH +: 2]),
                                  kpg_t'(code_pipe[LEVELS][1:0]));

    for (genvar i = 0; i < WIDTH; i++) begin : g_carry
        assign carry[i] = (kpg_t'(code_pipe[LEVELS][2*i +: 2]) == GEN);
    end
    assign carry[WIDTH] = (top_code == GEN);

    assign out_valid = valid_pipe[LEVELS];
    assign sum       = p_pipe[LEVELS] ^ carry[WIDTH-1:0];
    assign cout      = carry[WIDTH];
    assign ovf       = carry[WIDTH] ^ carry[WIDTH-1];
    assign out_tag   = tag_pipe[LEVELS];

endmodule

// File: tb/tb_kpg_prefix_adder_pipe.sv
// tb_kpg_prefix_adder_pipe: directed and random checks of the pipelined prefix adder
// against an arithmetic reference model. Honours KPG_ADD_SUB_EN.
module tb_kpg_prefix_adder_pipe;

    localparam int WIDTH = 32;
    localparam int TAG_W = 4;
    localparam int LAT   = 6;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             co;
        logic             ov;
        logic [TAG_W-1:0] tg;
    } result_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic [TAG_W-1:0] out_tag;

    int      checks   = 0;
    int      errors   = 0;
    int      accepted = 0;
    result_t expQ[$];
    logic    held     = 1'b0;
    result_t heldVal;

    kpg_prefix_adder_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef KPG_ADD_SUB_EN
        .sub       (sub),
`endif
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    // Reference: plain wide addition, overflow from operand/result signs.
    function automatic result_t model(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                                      input logic cc, input logic ss, input logic [TAG_W-1:0] tg);
        logic [WIDTH-1:0] be;
        logic             c0;
        logic [WIDTH:0]   full;
        result_t          r;
`ifdef KPG_ADD_SUB_EN
        be = ss ? ~bb : bb;
        c0 = ss ? 1'b1 : cc;
`else
        be = bb;
        c0 = cc;
        if (ss) be = bb;
`endif
        full = {1'b0, aa} + {1'b0, be} + {{WIDTH{1'b0}}, c0};
        r.s  = full[WIDTH-1:0];
        r.co = full[WIDTH];
        r.ov = (aa[WIDTH-1] == be[WIDTH-1]) && (full[WIDTH-1] != aa[WIDTH-1]);
        r.tg = tg;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: record accepted operands, compare delivered results, watch stalls.
    always @(negedge clk) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held) begin
                checkOutput("hold_valid", {63'd0, out_valid}, 64'd1);
                checkOutput("hold_data", {{(64-$bits(result_t)){1'b0}}, sum, cout, ovf, out_tag},
                            {{(64-$bits(result_t)){1'b0}}, heldVal});
            end
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_result", {63'd0, out_valid}, 64'd0);
                end else begin
                    result_t e;
                    e = expQ.pop_front();
                    checkOutput("sum", {32'd0, sum}, {32'd0, e.s});
                    checkOutput("cout", {63'd0, cout}, {63'd0, e.co});
                    checkOutput("ovf", {63'd0, ovf}, {63'd0, e.ov});
                    checkOutput("tag", {60'd0, out_tag}, {60'd0, e.tg});
                end
            end
            held    = out_valid && !out_ready;
            heldVal = {sum, cout, ovf, out_tag};
            if (in_valid && in_ready) begin
                expQ.push_back(model(a, b, cin, sub, in_tag));
                accepted++;
            end
        end
    end

    // One isolated operation with literal expectations and a latency count.
    task automatic applyStimulus(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                                 input logic cc, input logic ss, input logic [TAG_W-1:0] tg,
                                 input logic [WIDTH-1:0] eSum, input logic eCout, input logic eOvf);
        int cyc;
        @(posedge clk); #1;
        a = aa; b = bb; cin = cc; sub = ss; in_tag = tg;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (out_valid) break;
        end
        checkOutput("latency", 64'(cyc), 64'(LAT));
        checkOutput("lit_sum", {32'd0, sum}, {32'd0, eSum});
        checkOutput("lit_cout", {63'd0, cout}, {63'd0, eCout});
        checkOutput("lit_ovf", {63'd0, ovf}, {63'd0, eOvf});
        checkOutput("lit_tag", {60'd0, out_tag}, {60'd0, tg});
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int cyc;
        int seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0; in_tag = '0;
        #12;
        checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("rst_sum", {32'd0, sum}, 64'd0);
        checkOutput("rst_cout_ovf", {62'd0, cout, ovf}, 64'd0);
        checkOutput("rst_tag", {60'd0, out_tag}, 64'd0);
        checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        $display("[TB] directed vectors");
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'h1, 32'h0000_0000, 1'b1, 1'b0);
        applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'h2, 32'h8000_0000, 1'b0, 1'b1);
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 4'h3, 32'h0000_0000, 1'b1, 1'b0);
        applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 4'h4, 32'h0000_0000, 1'b1, 1'b1);
        applyStimulus(32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 4'h5, 32'h9999_9999, 1'b0, 1'b0);
        applyStimulus(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 4'h6, 32'h0000_0001, 1'b0, 1'b0);
`ifdef KPG_ADD_SUB_EN
        applyStimulus(32'd5, 32'd7, 1'b0, 1'b1, 4'h7, 32'hFFFF_FFFE, 1'b0, 1'b0);
        applyStimulus(32'd7, 32'd5, 1'b0, 1'b1, 4'h8, 32'h0000_0002, 1'b1, 1'b0);
`endif

        $display("[TB] stall hold");
        @(posedge clk); #1;
        a = 32'h0000_00FF; b = 32'h0000_0001; cin = 1'b0; sub = 1'b0; in_tag = 4'h9;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (LAT + 3) @(posedge clk);
        #1;
        checkOutput("stall_in_ready", {63'd0, in_ready}, 64'd0);
        checkOutput("stall_sum", {32'd0, sum}, 64'h100);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] random stream");
        cyc = 0;
        while (accepted < 1008 && cyc < 4000) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 7) != 0);
            a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
`ifdef KPG_ADD_SUB_EN
            sub = 1'($urandom_range(0, 1));
`endif
            in_tag = TAG_W'(cyc);
            cyc++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        cyc = 0;
        while ((expQ.size() != 0) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("drain_empty", 64'(expQ.size()), 64'd0);

        $display("[TB] reset mid-stream");
        sub = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            a = 32'(i * 3 + 1); b = 32'(i + 10); cin = 1'b0; in_tag = TAG_W'(i); in_valid = 1'b1;
        end
        @(posedge clk); #1;
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        expQ.delete();
        checkOutput("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("mid_rst_data", {27'd0, sum, cout, ovf, out_tag}, 64'd0);
        checkOutput("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checkOutput("no_stale_results", 64'(seen), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
